leve1_fetch_queue: RTL and testbench
====================================

// Module: leve1_fetch_queue
// PURPOSE
//  Instruction prefetch queue between the AXI read channel (RII) and the IF/ID handshake.
//  Issues sequential 4-byte fetches ahead of decode and buffers returned words with their PC.
//  On a redirect from EX, it discards in-flight and queued words.
//  Presents IF_VALID/IF_PC/IF_INSTR to LEVE1_ID and absorbs fetch latency.
// PARAMETERS
//  XLEN          `XLEN    address/PC width
//  DEPTH         4        queue entries; power of 2, >=2; also the max outstanding ARs
//  RESET_VECTOR  'h0      first fetch PC after reset; must be 4-byte aligned
// PORTS
//  CLK       in   1       clock, rising edge
//  RSTn      in   1       reset, asynchronous, active-low
//  IPC_WE    in   1       redirect strobe from EX
//  INEXT_PC  in   XLEN    redirect target; bits[1:0] ignored (treated as 0)
//  ARVALID   out  1       AXI read address valid
//  ARREADY   in   1       AXI read address ready
//  ARADDR    out  XLEN    fetch address, 4-byte aligned
//  RVALID    in   1       AXI read data valid
//  RREADY    out  1       AXI read data ready
//  RDATA     in   32      instruction word
//  IF_VALID  out  1       queue head valid toward ID
//  IF_READY  in   1       ID accepts head
//  IF_PC     out  XLEN    PC of head word
//  IF_INSTR  out  32      head instruction word
// BEHAVIOUR
//  Reset values:
//  - ARVALID=0, IF_VALID=0, RREADY=0, ARADDR=RESET_VECTOR, IF_PC=0, IF_INSTR=0.
//  - Internal state: fetch_pc=RESET_VECTOR, count=0, outstanding=0, discard=0.
//  RREADY:
//  - 1 in every cycle after reset deassertion.
//  - Credit accounting guarantees space, so R beats are never back-pressured.
//  AR issue: ARVALID rises when count+outstanding < DEPTH.
//  - ARADDR=fetch_pc.
//  - On AR handshake: fetch_pc+=4 (wraps modulo 2^XLEN) and outstanding+=1.
//  - After a handshake, ARVALID may stay high with the new ARADDR the next cycle (back-to-back issue).
//  AXI rule: once ARVALID=1, ARVALID and ARADDR hold stable until ARREADY, including across a redirect.
//  R beat (RVALID&RREADY): outstanding-=1.
//  - If discard>0: discard-=1 and the word is dropped.
//  - Otherwise: push {pc_tag, RDATA}. pc_tag is the PC of the oldest live request.
//  - Tags come from a DEPTH-entry tag FIFO written at AR handshake.
//  Pop: IF_VALID&IF_READY removes the head. IF_* come from registered queue storage.
//  - Latency RVALID beat to IF_VALID is 1 cycle when the queue is empty.
//  Redirect (IPC_WE=1), effective at the next edge:
//  - count=0 and IF_VALID=0 next cycle; queued words are lost.
//  - discard = outstanding after this cycle's AR/R updates, i.e. a same-cycle AR handshake is counted and a same-cycle live R beat is counted as dropped.
//  - fetch_pc = INEXT_PC&~3. A pending un-handshaked AR keeps its old ARADDR. Once that AR handshakes it also adds to discard and does not advance fetch_pc.
//  - A pop in the same cycle as IPC_WE is ignored (flush wins). ID discards it via its own flush input.
//  Simultaneous push and pop: count unchanged. Full (count=DEPTH) with pop: accepted.
//  Invariant: count+outstanding <= DEPTH. Assert in simulation.
//  IPC_WE repeated on consecutive cycles: the last target wins. discard accumulates correctly.
//  Reset mid-operation: all state returns to reset values immediately. The bench must not drive R beats for pre-reset requests.
// CONFIGURATION
//  LEVE1_IFQ_BYPASS_EN
//  - Defined: when count=0 and a live R beat arrives, IF_VALID=1 the same cycle with IF_PC=tag and IF_INSTR=RDATA (combinational).
//    - If IF_READY=1, the word is not written to the queue.
//    - IPC_WE in that cycle forces IF_VALID=0.
//  - Undefined: all IF_* outputs are driven from registers only; fixed 1-cycle latency.
// TESTING
//  1. Reset, ARREADY=1, RVALID 1 cycle after AR, IF_READY=1
//     -> ARADDR 0,4,8,...; IF_PC/IF_INSTR stream in order, 1 instr/cycle in steady state.
//  2. IF_READY=0, DEPTH=4
//     -> exactly 4 AR handshakes, then ARVALID=0. Queue full, count=4.
//     IF_READY=1 for 1 cycle -> one more AR at 0x10.
//  3. 3 ARs outstanding, IPC_WE with INEXT_PC=0x103
//     -> next 3 R beats dropped; next AR at 0x100; first IF_PC=0x100.
//  4. ARVALID high, ARREADY=0, IPC_WE to 0x200
//     -> ARADDR holds old value until handshake; that beat is dropped; next AR at 0x200.
//  5. IPC_WE, pop and live R beat in the same cycle
//     -> IF_VALID=0 next cycle, the R word is dropped, count=0.
//  6. BYPASS_EN defined, empty queue, R beat with IF_READY=1
//     -> IF_VALID the same cycle and count stays 0. Undefined: IF_VALID 1 cycle later.

Source files
------------

// File: rtl/leve1_fetch_queue.sv
// Instruction prefetch queue: issues sequential AXI reads and buffers returned words with their PC.
// Optional macro LEVE1_IFQ_BYPASS_EN forwards a live R beat straight to IF_* when the queue is empty.
`ifndef XLEN
`define XLEN 32
`endif

module leve1_fetch_queue #(
  parameter int              XLEN         = `XLEN,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IPC_WE,
  input  logic [XLEN-1:0] INEXT_PC,
  output logic            ARVALID,
  input  logic            ARREADY,
  output logic [XLEN-1:0] ARADDR,
  input  logic            RVALID,
  output logic            RREADY,
  input  logic [31:0]     RDATA,
  output logic            IF_VALID,
  input  logic            IF_READY,
  output logic [XLEN-1:0] IF_PC,
  output logic [31:0]     IF_INSTR
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [CW-1:0] count, count_n, outstanding, out_n, discard, discard_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, araddr_n;
  logic arvalid_n, stale, stale_n;
  logic [PW-1:0] q_head, q_tail, t_head, t_tail;
  logic [DEPTH-1:0][XLEN-1:0] q_pc, t_pc;
  logic [DEPTH-1:0][31:0] q_instr;
  logic ar_hs, r_beat, live, q_valid, push, pop;
  logic [XLEN-1:0] pc_tag;

  assign ar_hs   = ARVALID & ARREADY;
  assign r_beat  = RVALID & RREADY;
  assign live    = r_beat & (discard == '0);
  assign pc_tag  = t_pc[t_head];
  assign q_valid = (count != '0);
  assign pop     = q_valid & IF_READY & ~IPC_WE;

`ifdef LEVE1_IFQ_BYPASS_EN
  logic byp;
  assign byp  = ~q_valid & live;
  assign push = live & ~IPC_WE & ~(byp & IF_READY);
`else
  assign push = live & ~IPC_WE;
`endif

  always_comb begin
    out_n   = outstanding + CW'(ar_hs) - CW'(r_beat);
    count_n = IPC_WE ? '0 : count + CW'(push) - CW'(pop);
    if (IPC_WE) begin
      // Everything in flight after this edge is stale, including a held AR.
      discard_n  = out_n;
      stale_n    = ARVALID & ~ARREADY;
      fetch_pc_n = INEXT_PC & ~(XLEN'(3));
    end else begin
      discard_n  = discard - CW'(r_beat & ~live) + CW'(ar_hs & stale);
      stale_n    = stale & ~ar_hs;
      fetch_pc_n = (ar_hs & ~stale) ? fetch_pc + XLEN'(4) : fetch_pc;
    end
    if (ARVALID & ~ARREADY) begin
      arvalid_n = 1'b1;
      araddr_n  = ARADDR;
    end else begin
      arvalid_n = ({1'b0, count_n} + {1'b0, out_n}) < DEPTH_C;
      araddr_n  = fetch_pc_n;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      stale       <= 1'b0;
      fetch_pc    <= RESET_VECTOR;
      ARVALID     <= 1'b0;
      ARADDR      <= RESET_VECTOR;
      RREADY      <= 1'b0;
    end else begin
      count       <= count_n;
      outstanding <= out_n;
      discard     <= discard_n;
      stale       <= stale_n;
      fetch_pc    <= fetch_pc_n;
      ARVALID     <= arvalid_n;
      ARADDR      <= araddr_n;
      RREADY      <= 1'b1;
    end
  end

  // Tag FIFO holds the PC of every outstanding AR; each R beat, live or dropped, consumes one.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      t_pc    <= '0;
      t_head  <= '0;
      t_tail  <= '0;
      q_pc    <= '0;
      q_instr <= '0;
      q_head  <= '0;
      q_tail  <= '0;
    end else begin
      if (ar_hs) begin
        t_pc[t_tail] <= ARADDR;
        t_tail       <= t_tail + PW'(1);
      end
      if (r_beat) t_head <= t_head + PW'(1);
      if (push) begin
        q_pc[q_tail]    <= pc_tag;
        q_instr[q_tail] <= RDATA;
      end
      if (IPC_WE) begin
        q_head <= '0;
        q_tail <= '0;
      end else begin
        q_head <= q_head + PW'(pop);
        q_tail <= q_tail + PW'(push);
      end
    end
  end

  always_comb begin
    IF_VALID = q_valid;
    IF_PC    = q_pc[q_head];
    IF_INSTR = q_instr[q_head];
`ifdef LEVE1_IFQ_BYPASS_EN
    if (byp) begin
      IF_VALID = ~IPC_WE;
      IF_PC    = pc_tag;
      IF_INSTR = RDATA;
    end
`endif
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RSTn) assert (({1'b0, count} + {1'b0, outstanding}) <= DEPTH_C);
  end
`endif

endmodule

// File: tb/tb_leve1_fetch_queue.sv
// Directed bench for leve1_fetch_queue: a tiny AXI memory returns each read one cycle after AR.
module tb_leve1_fetch_queue;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IPC_WE;
  logic [31:0] INEXT_PC;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic        IF_VALID, IF_READY;
  logic [31:0] IF_PC, IF_INSTR;

  leve1_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_VECTOR(32'h0)) dut (
    .CLK(CLK), .RSTn(RSTn), .IPC_WE(IPC_WE), .INEXT_PC(INEXT_PC),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
    .IF_VALID(IF_VALID), .IF_READY(IF_READY), .IF_PC(IF_PC), .IF_INSTR(IF_INSTR)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] ar_log[$], pc_log[$], ins_log[$], rq[$];
  logic ar_rdy, r_en, if_rdy, redir;
  logic [31:0] redir_pc;
  int n;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h0013};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 unit later, DUT samples at the next rising edge.
  task automatic cyc();
    logic [31:0] a;
    @(negedge CLK);
    ARREADY  = ar_rdy;
    IF_READY = if_rdy;
    IPC_WE   = redir;
    INEXT_PC = redir_pc;
    if (r_en && rq.size() > 0) begin
      a = rq.pop_front();
      RVALID = 1'b1;
      RDATA  = instr_of(a);
    end else begin
      RVALID = 1'b0;
      RDATA  = '0;
    end
    #1;
    if (RSTn && ARVALID && ARREADY) begin
      ar_log.push_back(ARADDR);
      rq.push_back(ARADDR);
    end
    if (RSTn && IF_VALID && IF_READY && !IPC_WE) begin
      pc_log.push_back(IF_PC);
      ins_log.push_back(IF_INSTR);
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    ar_rdy = 0; r_en = 0; if_rdy = 0; redir = 0; redir_pc = '0;
    #1;
    chk("rst_arvalid",  32'(ARVALID),  32'd0);
    chk("rst_ifvalid",  32'(IF_VALID), 32'd0);
    chk("rst_rready",   32'(RREADY),   32'd0);
    chk("rst_araddr",   ARADDR,        32'h0);
    chk("rst_ifpc",     IF_PC,         32'h0);
    chk("rst_ifinstr",  IF_INSTR,      32'h0);
    rq.delete(); ar_log.delete(); pc_log.delete(); ins_log.delete();
    repeat (2) cyc();
    RSTn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RSTn = 1'b0; IPC_WE = 0; INEXT_PC = '0; ARREADY = 0; RVALID = 0; RDATA = '0; IF_READY = 0;

    // Streaming: one AR and one instruction per cycle once the pipe fills.
    do_reset();
    ar_rdy = 1; r_en = 1; if_rdy = 1;
    repeat (20) cyc();
    chk("t1_ar_cnt",  32'(ar_log.size()), 32'd20);
    chk("t1_pop_cnt", 32'(pc_log.size()), 32'd18);
    chk("t1_rready",  32'(RREADY), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_araddr", ar_log[i],  32'(4 * i));
      chk("t1_pc",     pc_log[i],  32'(4 * i));
      chk("t1_instr",  ins_log[i], instr_of(32'(4 * i)));
    end

    // Back-pressure from ID: queue fills to DEPTH, then one pop frees one AR credit.
    do_reset();
    ar_rdy = 1; r_en = 1; if_rdy = 0;
    repeat (10) cyc();
    chk("t2_ar_cnt",   32'(ar_log.size()), 32'd4);
    chk("t2_arvalid",  32'(ARVALID), 32'd0);
    chk("t2_ifvalid",  32'(IF_VALID), 32'd1);
    chk("t2_head_pc",  IF_PC, 32'h0);
    if_rdy = 1; cyc();
    if_rdy = 0; cyc();
    chk("t2_re_arvalid", 32'(ARVALID), 32'd1);
    chk("t2_re_araddr",  ARADDR, 32'h10);
    repeat (3) cyc();
    chk("t2_ar_cnt2",  32'(ar_log.size()), 32'd5);
    chk("t2_ar4",      ar_log[4], 32'h10);
    chk("t2_head_pc2", IF_PC, 32'h4);
    chk("t2_full_arv", 32'(ARVALID), 32'd0);
    chk("t2_pops",     32'(pc_log.size()), 32'd1);

    // Redirect with 3 ARs outstanding (third handshakes in the redirect cycle).
    do_reset();
    ar_rdy = 1; r_en = 0; if_rdy = 1;
    for (int i = 0; i < 20 && ar_log.size() < 2; i++) cyc();
    chk("t3_setup", 32'(ar_log.size()), 32'd2);
    redir = 1; redir_pc = 32'h103; cyc();
    chk("t3_hs_addr", ARADDR, 32'h8);
    redir = 0; ar_rdy = 0; cyc();
    chk("t3_new_arv",  32'(ARVALID), 32'd1);
    chk("t3_new_addr", ARADDR, 32'h100);
    ar_rdy = 1; r_en = 1;
    repeat (10) cyc();
    chk("t3_ar3",    ar_log[3],  32'h100);
    chk("t3_pc0",    pc_log[0],  32'h100);
    chk("t3_instr0", ins_log[0], instr_of(32'h100));
    chk("t3_pc1",    pc_log[1],  32'h104);

    // Redirect while an AR is held by ARREADY=0: address holds, its beat is dropped.
    do_reset();
    ar_rdy = 0; r_en = 0; if_rdy = 1;
    cyc();
    chk("t4_pend_arv",  32'(ARVALID), 32'd1);
    chk("t4_pend_addr", ARADDR, 32'h0);
    redir = 1; redir_pc = 32'h200; cyc();
    redir = 0; cyc();
    chk("t4_hold_arv",  32'(ARVALID), 32'd1);
    chk("t4_hold_addr", ARADDR, 32'h0);
    ar_rdy = 1; r_en = 1;
    repeat (8) cyc();
    chk("t4_ar0",    ar_log[0],  32'h0);
    chk("t4_ar1",    ar_log[1],  32'h200);
    chk("t4_pc0",    pc_log[0],  32'h200);
    chk("t4_instr0", ins_log[0], instr_of(32'h200));

    // Redirect coinciding with a pop and a live R beat.
    do_reset();
    ar_rdy = 1; r_en = 1; if_rdy = 1;
    repeat (6) cyc();
    chk("t5_pre_valid", 32'(IF_VALID), 32'd1);
    n = pc_log.size();
    chk("t5_pre_pops", 32'(n), 32'd4);
    redir = 1; redir_pc = 32'h300; cyc();
    redir = 0; cyc();
    chk("t5_flush_valid", 32'(IF_VALID), 32'd0);
    repeat (8) cyc();
    chk("t5_last_old", pc_log[n-1], 32'hC);
    chk("t5_first_new", pc_log[n], 32'h300);
    chk("t5_instr_new", ins_log[n], instr_of(32'h300));

    // Empty-queue latency from R beat to IF_VALID.
    do_reset();
    ar_rdy = 1; r_en = 0; if_rdy = 1;
    cyc();
    ar_rdy = 0; cyc();
    r_en = 1; cyc();
`ifdef LEVE1_IFQ_BYPASS_EN
    chk("t6_byp_valid", 32'(IF_VALID), 32'd1);
    chk("t6_byp_pc",    IF_PC, 32'h0);
    chk("t6_byp_instr", IF_INSTR, instr_of(32'h0));
    r_en = 0; cyc();
    chk("t6_byp_after", 32'(IF_VALID), 32'd0);
`else
    chk("t6_reg_same",  32'(IF_VALID), 32'd0);
    r_en = 0; cyc();
    chk("t6_reg_valid", 32'(IF_VALID), 32'd1);
    chk("t6_reg_instr", IF_INSTR, instr_of(32'h0));
`endif
    cyc();
    chk("t6_pops", 32'(pc_log.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
